bcd_addsub_serial: RTL and testbench

Digit-serial, multi-digit signed BCD adder/subtractor with a start/done handshake. It is the parametrised successor of the single-digit BCD subtractor. Width is set by `DIGITS`, and one block handles both add and subtract. Subtraction uses ten's complement internally and returns sign-magnitude with automatic re-complementing of negative results. It sits between the operand registers and the display drivers in the lab calculator datapath.

---
 rtl/bcd_addsub_serial_pkg.sv | 21 ++
 rtl/bcd_addsub_serial_digit_adder.sv | 25 ++
 rtl/bcd_addsub_serial.sv | 135 +++++++++++++
 tb/tb_bcd_addsub_serial.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_addsub_serial_pkg.sv
// Shared types and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NEGATE,
        S_DONE
    } bcd_as_state_t;

    function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
        return 4'd9 - digit;
    endfunction

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_addsub_serial_digit_adder.sv
// Single-digit decimal adder: x + y + cin with BCD correction and carry out.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    logic [BCD_W:0] raw_sum;

    always_comb begin
        raw_sum = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
        digit   = raw_sum[BCD_W-1:0];
        cout    = 1'b0;
        // Adding 6 wraps sums 10..19 back into 0..9 within four bits
        if (raw_sum > 5'd9) begin
            digit = raw_sum[BCD_W-1:0] + 4'd6;
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial signed BCD add/subtract; negative differences are re-complemented
// to sign-magnitude in a second serial pass through the shared digit adder.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sub,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] result,
    output logic                    negative,
    output logic                    overflow,
    output logic                    invalid
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_as_state_t           state;
    logic [BCD_W*DIGITS-1:0] a_reg;
    logic [BCD_W*DIGITS-1:0] b_reg;
    logic                    sub_reg;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic                    in_valid;

    logic [BCD_W-1:0] add_x;
    logic [BCD_W-1:0] add_y;
    logic             add_cin;
    logic [BCD_W-1:0] add_digit;
    logic             add_cout;

    always_comb begin
        in_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[i*BCD_W +: BCD_W]) || !is_bcd(b[i*BCD_W +: BCD_W]))
                in_valid = 1'b0;
        end
    end

    // CALC feeds A and (possibly nines-complemented) B; NEGATE feeds 9 - r_i and 0
    always_comb begin
        add_x   = a_reg[idx*BCD_W +: BCD_W];
        add_y   = sub_reg ? nines_comp(b_reg[idx*BCD_W +: BCD_W])
                          : b_reg[idx*BCD_W +: BCD_W];
        add_cin = carry;
        if (state == S_NEGATE) begin
            add_x = nines_comp(result[idx*BCD_W +: BCD_W]);
            add_y = '0;
        end
    end

    bcd_digit_adder u_digit_adder (
        .x     (add_x),
        .y     (add_y),
        .cin   (add_cin),
        .digit (add_digit),
        .cout  (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        sub_reg  <= sub;
                        result   <= '0;
                        negative <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        idx      <= '0;
                        carry    <= sub;
                        invalid  <= !in_valid;
                        state    <= in_valid ? S_CALC : S_DONE;
                    end
                end
                S_CALC: begin
                    result[idx*BCD_W +: BCD_W] <= add_digit;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        if (!sub_reg) begin
                            overflow <= add_cout;
                            state    <= S_DONE;
                        end else if (add_cout) begin
                            state <= S_DONE;
                        end else begin
                            // No end-around carry: A < B, so complement the difference
                            negative <= 1'b1;
                            idx      <= '0;
                            carry    <= 1'b1;
                            state    <= S_NEGATE;
                        end
                    end
                end
                S_NEGATE: begin
                    result[idx*BCD_W +: BCD_W] <= add_digit;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial (DIGITS = 4): directed table, handshake corners, random vs integer model.
module tb_bcd_addsub_serial;

    localparam int D = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [4*D-1:0] a;
    logic [4*D-1:0] b;
    logic          busy;
    logic          done;
    logic [4*D-1:0] result;
    logic          negative;
    logic          overflow;
    logic          invalid;

    int checks;
    int failures;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .negative (negative),
        .overflow (overflow),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        neg;
        logic        ovf;
        logic        inv;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r = '0;
        int m = n;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Expected outcome from plain integer arithmetic on the decimal values
    task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         output logic [15:0] res, output logic neg, output logic ovf,
                         output logic inv, output int lat);
        int ia, ib, s;
        inv = 1'b0;
        for (int i = 0; i < D; i++)
            if (va[i*4 +: 4] > 4'd9 || vb[i*4 +: 4] > 4'd9) inv = 1'b1;
        res = '0; neg = 1'b0; ovf = 1'b0;
        if (inv) begin
            lat = 1;
        end else begin
            ia = bcd2int(va);
            ib = bcd2int(vb);
            if (!vs) begin
                s   = ia + ib;
                ovf = (s >= 10000);
                res = int2bcd(s % 10000);
                lat = D + 1;
            end else begin
                s   = ia - ib;
                neg = (s < 0);
                res = int2bcd(neg ? -s : s);
                lat = neg ? 2 * D + 1 : D + 1;
            end
        end
    endtask

    task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vs);
        @(negedge clk);
        a = va; b = vb; sub = vs; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output logic seen);
        seen = 1'b0;
        cycles = 0;
        while (cycles < 100 && !seen) begin
            @(posedge clk);
            cycles++;
            #1 seen = done;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic [15:0] e_res, input logic e_neg,
                          input logic e_ovf, input logic e_inv, input int e_lat);
        int n;
        logic seen;
        launch(va, vb, vs);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n, seen);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(e_lat));
        chk({tag, "_result"}, 32'(result), 32'(e_res));
        chk({tag, "_negative"}, 32'(negative), 32'(e_neg));
        chk({tag, "_overflow"}, 32'(overflow), 32'(e_ovf));
        chk({tag, "_invalid"}, 32'(invalid), 32'(e_inv));
        @(posedge clk);
        #1 chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, er;
        logic        rs, en, eo, ei;
        int          el, n;
        logic        seen;

        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5};
        vecs[2] = '{16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, 1'b0, 5};
        vecs[3] = '{16'h0123, 16'h0500, 1'b1, 16'h0377, 1'b1, 1'b0, 1'b0, 9};
        vecs[4] = '{16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
        vecs[5] = '{16'h00A1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h0000, 16'h0F00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", {29'd0, negative, overflow, invalid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].res, vecs[i].neg, vecs[i].ovf, vecs[i].inv, vecs[i].lat);

        // Asynchronous reset while complementing a negative difference
        launch(16'h0123, 16'h0500, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_negate_busy", 32'(busy), 32'd1);
        chk("mid_negate_negative", 32'(negative), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_result", 32'(result), 32'd0);
        chk("async_rst_flags", {28'd0, done, negative, overflow, invalid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("after_rst", 16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, 1'b0, 5);

        // A start pulse while busy must not disturb the running add
        launch(16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        a = 16'h9999; b = 16'h0001; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, seen);
        chk("busy_start_seen", 32'(seen), 32'd1);
        chk("busy_start_latency", 32'(n + 1), 32'd5);
        chk("busy_start_result", 32'(result), 32'h6912);
        chk("busy_start_flags", {29'd0, negative, overflow, invalid}, 32'd0);

        for (int k = 0; k < 60; k++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < D; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) ra[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, en, eo, ei, el);
            run_op($sformatf("rnd%0d", k), ra, rb, rs, er, en, eo, ei, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
